// File: rtl/mem_arbiter_if.sv
// Request/ack bundle between the core's fetch and data ports, the arbiter
// and the shared memory. The arbiter uses the slave view, while the core and
// memory side (or a bench) uses the master view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction fetch port
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;
   logic              i_err;
   // data port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;
   // memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   // status
   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch port
// and the data port. One transaction at a time runs through IDLE -> BUSY -> DONE.
// The data port wins ties, but a fetch that has been passed over STARVE_LIMIT
// times in a row is forced through. A BUSY state that sees no mem_ack for
// TIMEOUT cycles is aborted and completes with err=1.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

   state_t            state_reg, state_next;
   logic              gnt_d_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              we_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              err_reg;
   logic [SC_W-1:0]   starve_cnt_reg;
   logic [TO_W-1:0]   to_cnt_reg;

   logic grant_i, grant_d, timeout_hit;

   // The fetch port wins only when alone or when it has been starved to the limit.
   assign grant_i     = bus.i_req && (!bus.d_req || (starve_cnt_reg == SC_MAX));
   assign grant_d     = bus.d_req && !grant_i;
   // A zero TIMEOUT disables the abort entirely.
   assign timeout_hit = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST);

   // State register. Reset drops mem_req at once because all outputs decode from state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic and output decode. Outputs are zero outside their owning state.
   always_comb begin
      state_next    = state_reg;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.i_ack     = 1'b0;
      bus.i_rdata   = '0;
      bus.i_err     = 1'b0;
      bus.d_ack     = 1'b0;
      bus.d_rdata   = '0;
      bus.d_err     = 1'b0;
      bus.busy      = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (grant_i)      state_next = I_BUSY;
            else if (grant_d) state_next = D_BUSY;
         end
         I_BUSY, D_BUSY: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we_reg;
            bus.mem_addr  = addr_reg;
            bus.mem_wdata = wdata_reg;
            // A mem_ack that coincides with the timeout still completes cleanly.
            if (bus.mem_ack || timeout_hit) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
            if (gnt_d_reg) begin
               bus.d_ack   = 1'b1;
               bus.d_rdata = rdata_reg;
               bus.d_err   = err_reg;
            end else begin
               bus.i_ack   = 1'b1;
               bus.i_rdata = rdata_reg;
               bus.i_err   = err_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch the winning request, track starvation and timeout, capture the result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_d_reg      <= 1'b0;
         addr_reg       <= '0;
         we_reg         <= 1'b0;
         wdata_reg      <= '0;
         rdata_reg      <= '0;
         err_reg        <= 1'b0;
         starve_cnt_reg <= '0;
         to_cnt_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_i || grant_d) begin
                  gnt_d_reg  <= grant_d;
                  addr_reg   <= grant_d ? bus.d_addr : bus.i_addr;
                  we_reg     <= grant_d && bus.d_we;
                  wdata_reg  <= grant_d ? bus.d_wdata : '0;
                  rdata_reg  <= '0;
                  err_reg    <= 1'b0;
                  to_cnt_reg <= '0;
                  // Only a data grant that leaves a fetch waiting counts toward starvation.
                  if (grant_d && bus.i_req)
                     starve_cnt_reg <= (starve_cnt_reg == SC_MAX) ? starve_cnt_reg
                                                                  : starve_cnt_reg + 1'b1;
                  else
                     starve_cnt_reg <= '0;
               end
            end
            I_BUSY, D_BUSY: begin
               if (bus.mem_ack) begin
                  rdata_reg <= we_reg ? '0 : bus.mem_rdata;
                  err_reg   <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_reg <= '0;
                  err_reg   <= 1'b1;
               end else if (TIMEOUT != 0) begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios (single fetch, write, starvation,
// timeout, ack at the limit, reset mid-transaction), then randomized traffic.
// The reference model works per transaction: it picks the grant from the
// request lines and a starvation count, draws a memory latency, and predicts
// the memory-side cycles, ack timing, rdata and err.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SL = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int txn_n    = 0;
   int starve_m = 0;   // model: consecutive data grants while a fetch waits
   bit in_done  = 0;   // 1 when the current negedge is in the ack cycle
   logic [31:0] mem_model [logic [31:0]];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h100 + 32'($urandom_range(0, 15)) * 4;
   endfunction

   task automatic new_i();
      bus.i_req  = 1'b1;
      bus.i_addr = rand_addr();
   endtask

   task automatic new_d();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom_range(0, 1));
      bus.d_addr  = rand_addr();
      bus.d_wdata = $urandom;
   endtask

   task automatic idle_cycle();
      @(posedge clk); @(negedge clk);
      check_val("idle_busy", bus.busy, 0);
      check_val("idle_mem_req", bus.mem_req, 0);
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      in_done = 0;
   endtask

   // One complete transaction. Called at a negedge with at least one request
   // pending; returns at the negedge of the ack cycle. lat is the BUSY cycle
   // (1-based) on which the memory acks; lat > TO means it never acks in time.
   task automatic do_round(input int lat, output bit obs_d);
      bit gd, ewe, terr;
      int nbusy;
      logic [31:0] ea, ewd, erd;
      if (in_done) begin
         @(posedge clk); @(negedge clk);
      end
      check_val("idle_busy", bus.busy, 0);
      check_val("idle_mem_req", bus.mem_req, 0);
      // acks arriving while idle must be ignored
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;

      gd = bus.d_req && !(bus.i_req && starve_m == SL);
      if (gd) starve_m = bus.i_req ? ((starve_m < SL) ? starve_m + 1 : SL) : 0;
      else    starve_m = 0;
      ea    = gd ? bus.d_addr : bus.i_addr;
      ewe   = gd && bus.d_we;
      ewd   = bus.d_wdata;
      terr  = (lat > TO);
      nbusy = terr ? TO : lat;
      erd   = (terr || ewe) ? 32'h0 : mem_rd(ea);

      for (int k = 1; k <= nbusy; k++) begin
         @(posedge clk); @(negedge clk);
         check_val("busy_mem_req", bus.mem_req, 1);
         check_val("busy_flag", bus.busy, 1);
         check_val("busy_mem_addr", bus.mem_addr, ea);
         check_val("busy_mem_we", bus.mem_we, ewe);
         if (ewe) check_val("busy_mem_wdata", bus.mem_wdata, ewd);
         check_val("busy_i_ack", bus.i_ack, 0);
         check_val("busy_d_ack", bus.d_ack, 0);
         if (k == lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = ewe ? $urandom : mem_rd(ea);
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
         end
      end

      @(posedge clk); @(negedge clk);
      if (ewe && !terr) mem_model[ea] = ewd;
      check_val("done_mem_req", bus.mem_req, 0);
      check_val("done_busy", bus.busy, 1);
      check_val("done_i_ack", bus.i_ack, !gd);
      check_val("done_i_rdata", bus.i_rdata, gd ? 32'h0 : erd);
      check_val("done_i_err", bus.i_err, gd ? 1'b0 : terr);
      check_val("done_d_ack", bus.d_ack, gd);
      check_val("done_d_rdata", bus.d_rdata, gd ? erd : 32'h0);
      check_val("done_d_err", bus.d_err, gd ? terr : 1'b0);
      obs_d = bus.d_ack;
      // acks arriving in the ack cycle must be ignored
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      in_done = 1;
      txn_n++;
      $display("txn %0d: port=%s addr=%08h we=%0b lat=%0d err=%0b rdata=%08h",
               txn_n, gd ? "D" : "I", ea, ewe, lat, terr, erd);
   endtask

   // Fetch held while the data port reissues right after every d_ack.
   task automatic starve_seq(output logic [4:0] seq);
      bit g;
      seq = '0;
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h80;
      if (!bus.d_req) new_d();
      for (int r = 0; r < 5; r++) begin
         do_round(int'($urandom_range(1, 4)), g);
         seq = {seq[3:0], g};
         if (g) new_d();
         else   bus.i_req = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit g;
      logic [4:0] seq;
      int lat;

      bus.i_req = 0; bus.i_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_mem_req", bus.mem_req, 0);
      check_val("rst_mem_addr", bus.mem_addr, 0);
      check_val("rst_mem_we", bus.mem_we, 0);
      check_val("rst_i_ack", bus.i_ack, 0);
      check_val("rst_d_ack", bus.d_ack, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      in_done = 0;
      starve_m = 0;

      // single fetch, memory acks on the first request cycle
      mem_model[32'h40] = 32'h8C22_0004;
      bus.i_req = 1'b1; bus.i_addr = 32'h40;
      do_round(1, g);
      bus.i_req = 1'b0;

      // write
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
      do_round(3, g);
      bus.d_req = 1'b0;

      // contention: D,D,D,D then the starved fetch
      starve_seq(seq);
      check_val("starve_order", seq, 5'b11110);
      do_round(2, g);
      check_val("after_starve_grant", g, 1);
      bus.d_req = 1'b0;

      // timeout on a read, then the next request proceeds normally
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
      do_round(100, g);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
      do_round(2, g);
      bus.d_req = 1'b0;

      // ack on the last BUSY cycle before the timeout
      bus.i_req = 1'b1; bus.i_addr = 32'h40;
      do_round(TO, g);
      bus.i_req = 1'b0;

      // build up starvation, then reset during a data transaction
      bus.i_req = 1'b1; bus.i_addr = 32'h80;
      new_d();
      for (int r = 0; r < 3; r++) begin
         do_round(int'($urandom_range(1, 4)), g);
         check_val("pre_reset_grant", g, 1);
         new_d();
      end
      @(posedge clk); @(negedge clk);
      bus.mem_ack = 1'b0;
      @(posedge clk); @(negedge clk);
      check_val("pre_reset_mem_req", bus.mem_req, 1);
      #2 reset = 1'b1;
      #1;
      check_val("async_rst_mem_req", bus.mem_req, 0);
      check_val("async_rst_busy", bus.busy, 0);
      check_val("async_rst_i_ack", bus.i_ack, 0);
      check_val("async_rst_d_ack", bus.d_ack, 0);
      @(negedge clk);
      reset = 1'b0;
      in_done = 0;
      starve_m = 0;
      new_d();
      starve_seq(seq);
      check_val("post_reset_order", seq, 5'b11110);
      do_round(1, g);
      bus.d_req = 1'b0;

      // randomized traffic
      for (int r = 0; r < 200; r++) begin
         while (!bus.i_req && !bus.d_req) begin
            idle_cycle();
            if ($urandom_range(0, 1) == 1) new_i();
            if ($urandom_range(0, 1) == 1) new_d();
         end
         lat = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, TO + 1));
         do_round(lat, g);
         if (g) begin
            if ($urandom_range(0, 1) == 1) new_d(); else bus.d_req = 1'b0;
         end else begin
            if ($urandom_range(0, 1) == 1) new_i(); else bus.i_req = 1'b0;
         end
         if (!bus.i_req && $urandom_range(0, 3) == 0) new_i();
         if (!bus.d_req && $urandom_range(0, 3) == 0) new_d();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
